// File: rtl/amp_window_scaler.sv
// amp_window_scaler
// Maps raw unsigned waveform samples onto the amplitude window [LO, HI].
// Limits are sanitised (clamped to full scale) and latched into shadow
// registers only on a valid period-start sample, so a period is never
// scaled with two different windows. Three-stage pipeline, no backpressure.

module amp_window_scaler #(
  parameter int DATA_W = 12
) (
  input  logic              FF_CLOCK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] SAMPLE_IN,
  input  logic              SAMPLE_VALID,
  input  logic              PERIOD_START,
  input  logic [31:0]       MIN_AMP,
  input  logic [31:0]       MAX_AMP,
  output logic [DATA_W-1:0] SAMPLE_OUT,
  output logic              OUT_VALID,
  output logic              RANGE_ERR
);

  localparam logic [DATA_W-1:0] FULL_SCALE = '1;
  // Rounding offset of one half LSB of the output (bit DATA_W-1 of the product).
  localparam logic [2*DATA_W-1:0] ROUND_HALF = (2*DATA_W)'(1) << (DATA_W - 1);

  // ---------------------------------------------------------------------------
  // Limit sanitising: index 0 is the min limit, index 1 the max limit.
  // ---------------------------------------------------------------------------
  logic [31:0]       amp_raw     [2];
  logic [DATA_W-1:0] amp_clamped [2];

  assign amp_raw[0] = MIN_AMP;
  assign amp_raw[1] = MAX_AMP;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_clamp
      assign amp_clamped[gi] = (amp_raw[gi] > 32'(FULL_SCALE)) ? FULL_SCALE
                                                                : amp_raw[gi][DATA_W-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shadow window registers
  // ---------------------------------------------------------------------------
  logic              shadow_load;
  logic [DATA_W-1:0] lo_reg, lo_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic              range_err_reg, range_err_next;

  assign shadow_load = SAMPLE_VALID & PERIOD_START;

  // Next window: reload on a qualified period start; an inverted request
  // collapses the window onto the (clamped) max limit and flags it.
  always_comb begin
    lo_next        = lo_reg;
    hi_next        = hi_reg;
    range_err_next = range_err_reg;
    if (shadow_load) begin
      if (amp_clamped[0] <= amp_clamped[1]) begin
        lo_next        = amp_clamped[0];
        hi_next        = amp_clamped[1];
        range_err_next = 1'b0;
      end else begin
        lo_next        = amp_clamped[1];
        hi_next        = amp_clamped[1];
        range_err_next = 1'b1;
      end
    end
  end

  // Shadow registers hold the full window out of reset (pass-through).
  always_ff @(posedge FF_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      lo_reg        <= '0;
      hi_reg        <= FULL_SCALE;
      range_err_reg <= 1'b0;
    end else begin
      lo_reg        <= lo_next;
      hi_reg        <= hi_next;
      range_err_reg <= range_err_next;
    end
  end

  assign RANGE_ERR = range_err_reg;

  // ---------------------------------------------------------------------------
  // Stage 1: capture sample and window. lo_next/hi_next already reflect a
  // load happening this cycle, so the period-start sample uses the new window.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] span_next;
  logic [DATA_W-1:0] s1_reg;
  logic [DATA_W-1:0] lo1_reg;
  logic [DATA_W-1:0] span1_reg;
  logic              v1_reg;

  // hi_next >= lo_next always holds, so the span never wraps.
  assign span_next = hi_next - lo_next;

  // Stage 1 data loads only on valid samples; valid always advances.
  always_ff @(posedge FF_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_reg    <= '0;
      lo1_reg   <= '0;
      span1_reg <= '0;
      v1_reg    <= 1'b0;
    end else begin
      v1_reg <= SAMPLE_VALID;
      if (SAMPLE_VALID) begin
        s1_reg    <= SAMPLE_IN;
        lo1_reg   <= lo_next;
        span1_reg <= span_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: p = span * (s + s[msb]) + half LSB.
  // Adding the sample MSB stretches 0..4095 onto 0..4096, which makes the top
  // end point land exactly on HI. The largest value, 4095*4096 + 2048, stays
  // below 2^24, so the 25-bit product's top bit is always zero and is dropped.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]     mult_next;
  logic [2*DATA_W-1:0] prod_next;
  logic [2*DATA_W-1:0] p2_reg;
  logic [DATA_W-1:0]   lo2_reg;
  logic                v2_reg;

  assign mult_next = {1'b0, s1_reg} + (DATA_W+1)'(s1_reg[DATA_W-1]);
  assign prod_next = (2*DATA_W)'(span1_reg) * (2*DATA_W)'(mult_next) + ROUND_HALF;

  // Stage 2 registers the rounded product alongside the window base.
  always_ff @(posedge FF_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      p2_reg  <= '0;
      lo2_reg <= '0;
      v2_reg  <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        p2_reg  <= prod_next;
        lo2_reg <= lo1_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: offset by the window base. The scaled part never exceeds span,
  // so lo + scaled <= HI <= full scale and no saturation is required.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] out_next;
  logic [DATA_W-1:0] sample_out_reg;
  logic              out_valid_reg;

  assign out_next = lo2_reg + p2_reg[2*DATA_W-1:DATA_W];

  // Output register holds the last valid sample through bubbles.
  always_ff @(posedge FF_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sample_out_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg <= v2_reg;
      if (v2_reg) begin
        sample_out_reg <= out_next;
      end
    end
  end

  assign SAMPLE_OUT = sample_out_reg;
  assign OUT_VALID  = out_valid_reg;

endmodule
